// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM state type and default memory timeout.
package pipeline_ctrl_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam int MEM_TIMEOUT_DEF = 16;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds an ID source (x0 never hazards).
module load_use_detect (
  input  logic       MemRead_EX,
  input  logic [4:0] RD_EX,
  input  logic [4:0] RS1_ID,
  input  logic [4:0] RS2_ID,
  output logic       lu
);
  assign lu = MemRead_EX & (RD_EX != 5'd0) & ((RD_EX == RS1_ID) | (RD_EX == RS2_ID));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: Mealy sequencer for load-use stalls, branch flushes and data-memory waits.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             PCSrc_MEM,
  input  logic             MemRead_MEM,
  input  logic             MemWrite_MEM,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             dmem_req,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  state_t          r_state;
  logic [WW-1:0]   r_wcnt;
  logic            r_err;
  logic [CNT_W-1:0] r_stall;
  logic w_lu, w_acc, w_wait, w_tout, w_hold, w_act, w_br, w_lus;
  load_use_detect u_lud (
    .MemRead_EX(MemRead_EX),
    .RD_EX     (RD_EX),
    .RS1_ID    (RS1_ID),
    .RS2_ID    (RS2_ID),
    .lu        (w_lu)
  );
  assign w_act  = !reset;
  assign w_acc  = MemRead_MEM | MemWrite_MEM;
  assign w_wait = r_state == MEM_WAIT;
  assign w_tout = w_wait & !dmem_ready & (r_wcnt == WW'(MEM_TIMEOUT - 1));
  // Freeze while an access is outstanding; a timeout retires the access with a plain advance.
  assign w_hold = !dmem_ready & (w_wait | w_acc) & !w_tout;
  assign w_br   = !w_hold & !w_tout & PCSrc_MEM;
  assign w_lus  = !w_hold & !w_tout & !PCSrc_MEM & w_lu;
  assign PC_write     = w_act & !w_hold & !w_lus;
  assign IF_ID_write  = w_act & !w_hold & !w_lus;
  assign ID_EX_write  = w_act & !w_hold;
  assign EX_MEM_write = w_act & !w_hold;
  assign MEM_WB_write = w_act & !w_hold;
  assign flush_IF_ID  = w_act & w_br;
  assign flush_ID_EX  = w_act & (w_br | w_lus);
  assign flush_EX_MEM = w_act & w_br;
  assign dmem_req     = w_act & (w_wait | w_acc);
  assign mem_error    = r_err;
  assign stall_cnt    = r_stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_wcnt  <= '0;
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_wait ? ((dmem_ready | w_tout) ? RUN : MEM_WAIT) : ((w_acc & !dmem_ready) ? MEM_WAIT : RUN);
      r_wcnt  <= (w_wait & !dmem_ready & !w_tout) ? r_wcnt + 1'b1 : '0;
      r_stall <= (!PC_write && r_stall != '1) ? r_stall + 1'b1 : r_stall;
      r_err   <= r_err | w_tout;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenario tasks with hand-computed expectations.
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset, MemRead_EX, PCSrc_MEM, MemRead_MEM, MemWrite_MEM, dmem_ready;
  logic [4:0]  RD_EX, RS1_ID, RS2_ID;
  logic        PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, dmem_req, mem_error;
  logic [31:0] stall_cnt;
  logic [4:0]  we;
  logic [2:0]  fl;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  assign we = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write};
  assign fl = {flush_IF_ID, flush_ID_EX, flush_EX_MEM};
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .RD_EX(RD_EX), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .PCSrc_MEM(PCSrc_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .dmem_ready(dmem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write), .EX_MEM_write(EX_MEM_write),
    .MEM_WB_write(MEM_WB_write), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
    .dmem_req(dmem_req), .mem_error(mem_error), .stall_cnt(stall_cnt)
  );
  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
  task automatic drive(input logic rst, input logic mre, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic pcs, input logic mrm, input logic mwm, input logic rdy);
    @(negedge clk);
    reset = rst; MemRead_EX = mre; RD_EX = rd; RS1_ID = rs1; RS2_ID = rs2;
    PCSrc_MEM = pcs; MemRead_MEM = mrm; MemWrite_MEM = mwm; dmem_ready = rdy;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
  endtask
  task automatic test_reset();
    drive(1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0);
    n_cmp++; if (we !== 5'b00000) begin n_err++; $display("FAIL reset_we got %b want 00000", we); end
    n_cmp++; if (fl !== 3'b000) begin n_err++; $display("FAIL reset_fl got %b want 000", fl); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", dmem_req); end
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    n_cmp++; if (mem_error !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", mem_error); end
    idle();
    n_cmp++; if (we !== 5'b11111 || fl !== 3'b000 || dmem_req !== 1'b0) begin n_err++; $display("FAIL idle_run got we=%b fl=%b req=%b want 11111/000/0", we, fl, dmem_req); end
  endtask
  task automatic test_load_use();
    drive(0, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0, 1);
    n_cmp++; if (we !== 5'b00111) begin n_err++; $display("FAIL lu_we got %b want 00111", we); end
    n_cmp++; if (fl !== 3'b010) begin n_err++; $display("FAIL lu_fl got %b want 010", fl); end
    idle();
    n_cmp++; if (we !== 5'b11111 || fl !== 3'b000) begin n_err++; $display("FAIL lu_next got we=%b fl=%b want 11111/000", we, fl); end
    n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_stall got %0d want 1", stall_cnt); end
    drive(0, 0, 5'd7, 5'd7, 5'd7, 0, 0, 0, 1);
    n_cmp++; if (we !== 5'b11111 || fl !== 3'b000) begin n_err++; $display("FAIL no_load got we=%b fl=%b want 11111/000", we, fl); end
  endtask
  task automatic test_x0();
    drive(0, 1, 5'd0, 5'd0, 5'd9, 0, 0, 0, 1);
    n_cmp++; if (we !== 5'b11111 || fl !== 3'b000) begin n_err++; $display("FAIL x0 got we=%b fl=%b want 11111/000", we, fl); end
    idle();
    n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL x0_stall got %0d want 1", stall_cnt); end
  endtask
  task automatic test_branch_lu();
    drive(0, 1, 5'd4, 5'd4, 5'd1, 1, 0, 0, 1);
    n_cmp++; if (we !== 5'b11111) begin n_err++; $display("FAIL br_we got %b want 11111", we); end
    n_cmp++; if (fl !== 3'b111) begin n_err++; $display("FAIL br_fl got %b want 111", fl); end
    idle();
    n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL br_stall got %0d want 1", stall_cnt); end
  endtask
  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
      n_cmp++; if (we !== 5'b00000 || fl !== 3'b000 || dmem_req !== 1'b1) begin n_err++; $display("FAIL wait%0d got we=%b fl=%b req=%b want 00000/000/1", i, we, fl, dmem_req); end
    end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    n_cmp++; if (we !== 5'b11111 || dmem_req !== 1'b1) begin n_err++; $display("FAIL wait_ready got we=%b req=%b want 11111/1", we, dmem_req); end
    idle();
    n_cmp++; if (dmem_req !== 1'b0 || we !== 5'b11111) begin n_err++; $display("FAIL wait_done got we=%b req=%b want 11111/0", we, dmem_req); end
    n_cmp++; if (stall_cnt !== 32'd4) begin n_err++; $display("FAIL wait_stall got %0d want 4", stall_cnt); end
  endtask
  task automatic test_wait_lu();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    n_cmp++; if (we !== 5'b00000) begin n_err++; $display("FAIL wlu_hold got %b want 00000", we); end
    drive(0, 1, 5'd6, 5'd6, 5'd2, 0, 1, 0, 1);
    n_cmp++; if (we !== 5'b00111 || fl !== 3'b010) begin n_err++; $display("FAIL wlu_ready got we=%b fl=%b want 00111/010", we, fl); end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    n_cmp++; if (we !== 5'b11111 || dmem_req !== 1'b1) begin n_err++; $display("FAIL fast_acc got we=%b req=%b want 11111/1", we, dmem_req); end
    idle();
    n_cmp++; if (stall_cnt !== 32'd6) begin n_err++; $display("FAIL wlu_stall got %0d want 6", stall_cnt); end
  endtask
  task automatic test_timeout();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      n_cmp++; if (we !== 5'b00000 || dmem_req !== 1'b1 || mem_error !== 1'b0) begin n_err++; $display("FAIL to_wait%0d got we=%b req=%b err=%b want 00000/1/0", i, we, dmem_req, mem_error); end
    end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    n_cmp++; if (we !== 5'b11111 || dmem_req !== 1'b1) begin n_err++; $display("FAIL to_retire got we=%b req=%b want 11111/1", we, dmem_req); end
    idle();
    n_cmp++; if (mem_error !== 1'b1) begin n_err++; $display("FAIL to_err got %b want 1", mem_error); end
    n_cmp++; if (dmem_req !== 1'b0 || we !== 5'b11111) begin n_err++; $display("FAIL to_run got we=%b req=%b want 11111/0", we, dmem_req); end
    n_cmp++; if (stall_cnt !== 32'd22) begin n_err++; $display("FAIL to_stall got %0d want 22", stall_cnt); end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1);
    idle();
    n_cmp++; if (mem_error !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", mem_error); end
  endtask
  task automatic test_reset_in_wait();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    n_cmp++; if (we !== 5'b00000 || dmem_req !== 1'b1) begin n_err++; $display("FAIL rw_wait got we=%b req=%b want 00000/1", we, dmem_req); end
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    n_cmp++; if (dmem_req !== 1'b0 || we !== 5'b00000) begin n_err++; $display("FAIL rw_abort got we=%b req=%b want 00000/0", we, dmem_req); end
    idle();
    n_cmp++; if (stall_cnt !== 32'd0 || mem_error !== 1'b0) begin n_err++; $display("FAIL rw_clear got stall=%0d err=%b want 0/0", stall_cnt, mem_error); end
    n_cmp++; if (dmem_req !== 1'b0 || we !== 5'b11111) begin n_err++; $display("FAIL rw_run got we=%b req=%b want 11111/0", we, dmem_req); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_branch_lu();
    test_mem_wait();
    test_wait_lu();
    test_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central pipeline sequencer for the 5-stage RISC-V core. It drives the write enables and flushes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, flushes the pipeline on taken branches, and freezes the pipeline while the data memory completes a multi-cycle access. It also keeps a stall-cycle counter and a sticky memory-timeout flag.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum number of wait cycles for `dmem_ready` before the access is abandoned.
- CNT_W, default 32: width of the stall counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead_EX  in  1  instruction in EX is a load.
- RD_EX  in  5  destination register of the instruction in EX.
- RS1_ID, RS2_ID  in  5 each  source registers of the instruction in ID.
- PCSrc_MEM  in  1  branch in MEM is taken (`Branch_MEM & ZERO_MEM`, resolved upstream).
- MemRead_MEM, MemWrite_MEM  in  1 each  the instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the current access this cycle.
- PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write  out  1 each  register write enables.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  load a bubble (all zeros) into that register on this edge.
- dmem_req  out  1  data-memory access request.
- mem_error  out  1  sticky flag: an access timed out.
- stall_cnt  out  CNT_W  count of cycles in which PC_write was 0, excluding reset.

## Operation
- FSM with two states: RUN and MEM_WAIT. Outputs are Mealy: combinational from the current state and the inputs.
- Load-use hazard (`lu`) is true when `MemRead_EX & RD_EX!=0 & (RD_EX==RS1_ID | RD_EX==RS2_ID)`.
- RUN, memory access in MEM (`MemRead_MEM|MemWrite_MEM`):
  - `dmem_req=1`.
  - If `dmem_ready=0`: all five write enables are 0, all flushes are 0, and the FSM moves to MEM_WAIT with the wait counter cleared.
  - If `dmem_ready=1`: the cycle proceeds as a normal RUN cycle.
- RUN, normal cycle, resolved in priority order:
  1. `PCSrc_MEM`: all write enables 1; `flush_IF_ID`, `flush_ID_EX` and `flush_EX_MEM` all 1. The load-use hazard is ignored this cycle.
  2. `lu`: `PC_write=0`, `IF_ID_write=0`, `flush_ID_EX=1`, `ID_EX_write=1`, `EX_MEM_write=1`, `MEM_WB_write=1`.
  3. Otherwise: all write enables 1, all flushes 0.
- MEM_WAIT:
  - `dmem_req=1`.
  - While `dmem_ready=0`: all enables and flushes are 0 and the wait counter increments.
  - When `dmem_ready=1`: this cycle is evaluated exactly like a RUN normal cycle (the priority list above applies), and the FSM goes to RUN.
  - When the wait counter reaches MEM_TIMEOUT-1 with `dmem_ready` still 0: `mem_error` is set, the FSM goes to RUN, and on that edge all enables are 1 so the faulting access is retired.
- The wait counter is `$clog2(MEM_TIMEOUT)` bits wide. It is compared for equality, never wraps, and clears on entry to MEM_WAIT.
- `stall_cnt` increments by 1 on every non-reset cycle with `PC_write=0`. It saturates at all-ones.
- `mem_error` is cleared only by reset.

## Timing
- While `reset=1`, regardless of all other inputs:
  - all write enables 0, all flushes 0, `dmem_req=0`;
  - on the edge: FSM goes to RUN, wait counter 0, `stall_cnt=0`, `mem_error=0`.
- Reset asserted during MEM_WAIT aborts the access. `dmem_req` drops in the same cycle.
- Hazard responses have zero-cycle latency: enables and flushes are valid in the same cycle as their causing inputs and act on the next clk edge.
- A load-use hazard costs exactly 1 stall cycle. On the following cycle the load is in MEM, so `lu` is false.
- A taken branch costs 3 squashed instructions and 0 stall cycles.
- A memory access with N wait cycles (`dmem_ready` first high in cycle N+1 after the request) freezes the pipeline for N cycles and adds N to `stall_cnt`.
- `dmem_req` stays high continuously from the first request cycle through the ready cycle or timeout cycle.

## Structure
- Package `pipeline_ctrl_pkg`: FSM state enum (RUN, MEM_WAIT) and the default MEM_TIMEOUT constant.
- One combinational sub-module `load_use_detect` (inputs MemRead_EX, RD_EX, RS1_ID, RS2_ID; output `lu`).
- FSM, wait counter, stall counter and error flag live in the top module.

## Test plan
- Load-use: `MemRead_EX=1`, `RD_EX=5`, `RS2_ID=5` for one cycle → `PC_write=0`, `IF_ID_write=0`, `flush_ID_EX=1`, other enables 1; next cycle all enables 1; `stall_cnt=1`.
- Load-use on x0: `RD_EX=0`, `RS1_ID=0`, `MemRead_EX=1` → no stall, all enables 1, `stall_cnt` unchanged.
- Branch plus load-use in the same cycle: `PCSrc_MEM=1` with `lu` true → all enables 1, all three flushes 1, `stall_cnt` unchanged.
- Memory wait: `MemRead_MEM=1`, `dmem_ready` low for 3 cycles then high →
  - `dmem_req` high for 4 cycles;
  - enables 0 for 3 cycles, then 1;
  - FSM RUN→MEM_WAIT→RUN;
  - `stall_cnt=3`.
- Timeout: `MemWrite_MEM=1`, `dmem_ready` held 0, MEM_TIMEOUT=16 → `mem_error=1` after 16 wait cycles, FSM returns to RUN with all enables 1; `mem_error` stays 1 until reset.
- Reset in MEM_WAIT: `reset=1` in the 2nd wait cycle → same cycle `dmem_req=0` and enables 0; after the edge FSM=RUN, `stall_cnt=0`, `mem_error=0`.
